// File: rtl/sword_board_disp_pkg.sv
// Shared types, frame geometry and the active-low hex segment table for the
// SWORD board display driver.
package sword_board_disp_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2,
    ST_WAIT  = 2'd3
  } disp_state_t;

  localparam int SEG_BITS = 64;
  localparam int LED_BITS = 16;
  localparam int DIGITS   = 8;

  // Byte layout {dp,g,f,e,d,c,b,a}, active low; dp is set (off) in the table.
  function automatic logic [7:0] hex_seg(input logic [3:0] nib);
    logic [7:0] code;
    case (nib)
      4'h0: code = 8'hC0;
      4'h1: code = 8'hF9;
      4'h2: code = 8'hA4;
      4'h3: code = 8'hB0;
      4'h4: code = 8'h99;
      4'h5: code = 8'h92;
      4'h6: code = 8'h82;
      4'h7: code = 8'hF8;
      4'h8: code = 8'h80;
      4'h9: code = 8'h90;
      4'hA: code = 8'h88;
      4'hB: code = 8'h83;
      4'hC: code = 8'hC6;
      4'hD: code = 8'hA1;
      4'hE: code = 8'h86;
      default: code = 8'h8E;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/sword_board_disp_hex7seg.sv
// One digit of the display: nibble plus enable and dot to an active-low
// segment byte. A blanked digit is all ones and ignores its dot.
module sword_hex7seg
  import sword_board_disp_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       en,
  input  logic       dot,
  output logic [7:0] seg
);

  logic [7:0] code;

  always_comb begin
    code = hex_seg(nib);
    seg  = en ? (code & {~dot, 7'h7F}) : 8'hFF;
  end

endmodule

// File: rtl/sword_board_disp.sv
// Serial driver for the SWORD 8-digit seven-segment chain and 16-LED chain;
// snapshots inputs once per frame and shifts both frames out MSB first.
//
// state    | meaning
// ST_LOAD  | snapshot inputs into shift registers, outputs disabled
// ST_SHIFT | clock 64 seg bits out (first 16 also go down the LED chain)
// ST_LATCH | enable the chain outputs
// ST_WAIT  | hold the displayed frame for REFRESH_GAP cycles
module sword_board_disp
  import sword_board_disp_pkg::*;
#(
  parameter int CLK_DIV     = 2,
  parameter int REFRESH_GAP = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  en,
  input  logic [31:0] data,
  input  logic [7:0]  dot,
  input  logic [15:0] led,
  output logic        seg_clk,
  output logic        seg_en,
  output logic        seg_clr_n,
  output logic        seg_do,
  output logic        led_clk,
  output logic        led_en,
  output logic        led_clr_n,
  output logic        led_do
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W = (REFRESH_GAP > 1) ? $clog2(REFRESH_GAP) : 1;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(REFRESH_GAP - 1);
  localparam logic [5:0] SEG_LAST = 6'(SEG_BITS - 1);
  localparam logic [5:0] LED_LAST = 6'(LED_BITS - 1);

  disp_state_t state, state_nxt;

  logic [SEG_BITS-1:0] seg_frame;
  logic [SEG_BITS-1:0] seg_sr;
  logic [LED_BITS-1:0] led_sr;
  logic [5:0]          bit_cnt;
  logic [DIV_W-1:0]    div_cnt;
  logic [GAP_W-1:0]    wait_cnt;
  logic                div_tc, bit_tc, wait_tc;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    sword_hex7seg u_hex (
      .nib (data[4*i +: 4]),
      .en  (en[i]),
      .dot (dot[i]),
      .seg (seg_frame[8*i +: 8])
    );
  end

  // Data comes straight off the shift-register MSBs; ones shift in behind.
  assign seg_do = seg_sr[SEG_BITS-1];
  assign led_do = led_sr[LED_BITS-1];

  always_ff @(posedge clk) begin
    if (rst) state <= ST_LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    div_tc    = (div_cnt == '0);
    bit_tc    = (bit_cnt == SEG_LAST);
    wait_tc   = (wait_cnt == '0);
    case (state)
      ST_LOAD:  state_nxt = ST_SHIFT;
      ST_SHIFT: if (div_tc && seg_clk && bit_tc) state_nxt = ST_LATCH;
      ST_LATCH: state_nxt = ST_WAIT;
      ST_WAIT:  if (wait_tc) state_nxt = ST_LOAD;
      default:  state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_clk   <= 1'b0;
      led_clk   <= 1'b0;
      seg_en    <= 1'b0;
      led_en    <= 1'b0;
      seg_clr_n <= 1'b0;
      led_clr_n <= 1'b0;
      seg_sr    <= '1;
      led_sr    <= '1;
      bit_cnt   <= '0;
      div_cnt   <= DIV_LOAD;
      wait_cnt  <= GAP_LOAD;
    end else begin
      seg_clr_n <= 1'b1;
      led_clr_n <= 1'b1;
      case (state)
        ST_LOAD: begin
          seg_sr  <= seg_frame;
          led_sr  <= ~led;
          bit_cnt <= '0;
          div_cnt <= DIV_LOAD;
          seg_clk <= 1'b0;
          led_clk <= 1'b0;
          seg_en  <= 1'b0;
          led_en  <= 1'b0;
        end
        ST_SHIFT: begin
          if (!div_tc) begin
            div_cnt <= div_cnt - 1'b1;
          end else begin
            div_cnt <= DIV_LOAD;
            if (!seg_clk) begin
              seg_clk <= 1'b1;
              led_clk <= (bit_cnt <= LED_LAST);
            end else begin
              // Falling phase: advance to the next bit.
              seg_clk <= 1'b0;
              led_clk <= 1'b0;
              seg_sr  <= {seg_sr[SEG_BITS-2:0], 1'b1};
              led_sr  <= {led_sr[LED_BITS-2:0], 1'b1};
              if (!bit_tc) bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        ST_LATCH: begin
          seg_en   <= 1'b1;
          led_en   <= 1'b1;
          wait_cnt <= GAP_LOAD;
        end
        ST_WAIT: begin
          if (!wait_tc) wait_cnt <= wait_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sword_board_disp.sv
// Scoreboard bench for sword_board_disp: stimulus queues expected frames, a
// monitor reassembles the serial chains and checks each completed frame.
module tb_sword_board_disp;

  localparam int CLK_DIV = 2;
  localparam int GAP     = 8;
  localparam int PERIOD  = 1 + 64 * 2 * CLK_DIV + 1 + GAP;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  en = 8'hFF;
  logic [31:0] data = '0;
  logic [7:0]  dot = '0;
  logic [15:0] led = '0;
  logic        seg_clk, seg_en, seg_clr_n, seg_do;
  logic        led_clk, led_en, led_clr_n, led_do;

  always #5 clk = ~clk;

  sword_board_disp #(.CLK_DIV(CLK_DIV), .REFRESH_GAP(GAP)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .data      (data),
    .dot       (dot),
    .led       (led),
    .seg_clk   (seg_clk),
    .seg_en    (seg_en),
    .seg_clr_n (seg_clr_n),
    .seg_do    (seg_do),
    .led_clk   (led_clk),
    .led_en    (led_en),
    .led_clr_n (led_clr_n),
    .led_do    (led_do)
  );

  typedef struct {
    logic [63:0] seg;
    logic [15:0] led;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, want %h", name, act, req);
  endtask

  function automatic logic [7:0] out_vec();
    return {seg_clk, led_clk, seg_do, led_do, seg_en, led_en, seg_clr_n, led_clr_n};
  endfunction

  // Monitor
  logic        prev_seg_clk = 1'b0, prev_led_clk = 1'b0, prev_seg_en = 1'b0;
  logic [63:0] seg_cap = '0;
  logic [15:0] led_cap = '0;
  int          seg_n = 0, led_n = 0, frames = 0, cyc = 0, last_rise = 0;
  bit          period_ok = 1'b0;
  exp_t        e;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        seg_n = 0;
        led_n = 0;
        period_ok = 1'b0;
      end else begin
        if (seg_clk && !prev_seg_clk) begin
          seg_cap = {seg_cap[62:0], seg_do};
          seg_n++;
        end
        if (led_clk && !prev_led_clk) begin
          led_cap = {led_cap[14:0], led_do};
          led_n++;
        end
        if (seg_en && !prev_seg_en) begin
          check("expected_frame_queued", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("seg_frame", seg_cap, e.seg);
            check("seg_bit_count", seg_n, 64);
            check("led_frame", led_cap, e.led);
            check("led_bit_count", led_n, 16);
            check("led_en_with_seg_en", led_en, 1);
            check("idle_do_high", {seg_do, led_do}, 2'b11);
          end
          if (period_ok) check("frame_period", cyc - last_rise, PERIOD);
          last_rise = cyc;
          period_ok = 1'b1;
          seg_n = 0;
          led_n = 0;
          frames++;
        end
      end
      prev_seg_clk = seg_clk;
      prev_led_clk = led_clk;
      prev_seg_en  = seg_en;
    end
  end

  task automatic wait_frame();
    int f0 = frames;
    int n = 0;
    while (frames == f0 && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("frame_arrived", frames != f0, 1);
  endtask

  task automatic push(input logic [63:0] s, input logic [15:0] l);
    exp_t x;
    x.seg = s;
    x.led = l;
    exp_q.push_back(x);
  endtask

  initial begin
    int n;
    en = 8'hFF; data = 32'h0123_4567; dot = 8'h00; led = 16'hA5F0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", out_vec(), 8'b0011_0000);
    push(64'hC0F9A4B0999282F8, 16'h5A0F);
    rst = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!seg_clk && n < 20);
    check("first_seg_clk_rise_latency", n, 1 + CLK_DIV);
    check("clr_n_released", {seg_clr_n, led_clr_n}, 2'b11);
    wait_frame();

    // Dot and blanking
    en = 8'b1111_1110; data = 32'h89AB_CDEF; dot = 8'b1000_0001; led = 16'h1234;
    push(64'h00908883C6A186FF, 16'hEDCB);
    wait_frame();

    // Snapshot stability: inputs change while the frame is shifting
    en = 8'hFF; data = 32'h0F1E_2D3C; dot = 8'h0F; led = 16'h0001;
    push(64'hC08EF98624213046, 16'hFFFE);
    repeat (60) @(negedge clk);
    #1;
    en = 8'hFF; data = 32'hFFFF_FFFF; dot = 8'hFF; led = 16'hFFFF;
    push(64'h0E0E0E0E0E0E0E0E, 16'h0000);
    wait_frame();
    wait_frame();

    // Reset in the middle of SHIFT
    en = 8'h0F; data = 32'h0000_00A5; dot = 8'h00; led = 16'h00FF;
    push(64'hFFFFFFFFC0C08892, 16'hFF00);
    n = 0;
    while (seg_n < 30 && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("reached_bit_30", seg_n, 30);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("midframe_reset_outputs", out_vec(), 8'b0011_0000);
    rst = 1'b0;
    wait_frame();

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
